// File: rtl/ex.sv
// MIPS32 execute stage: combinational logic/shift/arith ALU plus a 32-step restoring divider FSM.
// ALU results are zero-latency; DIV/DIVU hold stallreq_o until the one-cycle END state, and flush_i cancels a divide.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr_i,
    input  logic        wreg_i,
    output logic        wreg_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic [4:0]  cnt_q;
    logic        qneg_q, rneg_q;
    logic [31:0] hi_q, lo_q;

    logic        is_div, is_sdiv;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, diff;
    logic        ge;
    logic [31:0] rem_next, quo_next;
    logic [31:0] logic_res, shift_res, arith_res, alu_res;

    assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv = (aluop_i == OP_DIV);
    assign abs_a   = (is_sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
    assign abs_b   = (is_sdiv && reg2_i[31]) ? -reg2_i : reg2_i;

    // acc holds {remainder, remaining dividend bits}; bit 32 of diff is the borrow.
    assign shifted  = acc_q[63:31];
    assign diff     = shifted - {1'b0, b_q};
    assign ge       = ~diff[32];
    assign rem_next = ge ? diff[31:0] : shifted[31:0];
    assign quo_next = {acc_q[30:0], ge};

    always_comb begin
        logic_res = 32'h0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = 32'h0;
        endcase
        shift_res = 32'h0;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default: shift_res = 32'h0;
        endcase
        arith_res = 32'h0;
        case (aluop_i)
            OP_ADDU: arith_res = reg1_i + reg2_i;
            OP_SUBU: arith_res = reg1_i - reg2_i;
            OP_SLT:  arith_res = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
            default: arith_res = 32'h0;
        endcase
        alu_res = 32'h0;
        case (alusel_i)
            3'b001:  alu_res = logic_res;
            3'b010:  alu_res = shift_res;
            3'b100:  alu_res = arith_res;
            default: alu_res = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE:   if (is_div) state_d = (reg2_i == 32'h0) ? S_BYZERO : S_ON;
            S_BYZERO: state_d = S_END;
            S_ON:     if (cnt_q == 5'd31) state_d = S_END;
            S_END:    state_d = S_FREE;
            default:  state_d = S_FREE;
        endcase
        if (flush_i) state_d = S_FREE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 64'h0;
            b_q    <= 32'h0;
            cnt_q  <= 5'd0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= 32'h0;
            lo_q   <= 32'h0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (is_div) begin
                        acc_q  <= {32'h0, abs_a};
                        b_q    <= abs_b;
                        cnt_q  <= 5'd0;
                        qneg_q <= is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                        rneg_q <= is_sdiv && reg1_i[31];
                    end
                end
                S_BYZERO: begin
                    hi_q <= 32'h0;
                    lo_q <= 32'h0;
                end
                S_ON: begin
                    acc_q <= {rem_next, quo_next};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        lo_q <= qneg_q ? -quo_next : quo_next;
                        hi_q <= rneg_q ? -rem_next : rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wreg_o     = 1'b0;
        waddr_o    = 5'd0;
        wdata_o    = 32'h0;
        whilo_o    = 1'b0;
        hi_o       = 32'h0;
        lo_o       = 32'h0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wreg_o  = wreg_i;
            waddr_o = waddr_i;
            wdata_o = alu_res;
            if (state_q == S_END) begin
                hi_o = hi_q;
                lo_o = lo_q;
            end
            if (!flush_i) begin
                whilo_o    = (state_q == S_END);
                stallreq_o = ((state_q == S_FREE) && is_div) ||
                             (state_q == S_BYZERO) || (state_q == S_ON);
            end
        end
    end
endmodule

// File: tb/tb_ex.sv
// Directed testbench for the ex stage: ALU vectors, divider timing/results, flush and reset interruption.
module tb_ex;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    logic        clk = 1'b0;
    logic        rst, flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  waddr_i;
    logic        wreg_i;
    logic        wreg_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i),
        .waddr_i(waddr_i), .wreg_i(wreg_i),
        .wreg_o(wreg_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; wreg_i = 1'b1; waddr_i = 5'd3;
        set_op(8'h25, 3'b001, 32'h0000F0F0, 32'h00000F0F);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wreg_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_alu_outs: wreg=%b waddr=%0d wdata=%h, want 0/0/0", wreg_o, waddr_o, wdata_o);
        end
        set_op(OP_DIVU, 3'b000, 32'd100, 32'd7);
        #1;
        checks++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_div_outs: stall=%b whilo=%b hi=%h lo=%h, want all 0", stallreq_o, whilo_o, hi_o, lo_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; wreg_i = 1'b0;
        set_op(8'h00, 3'b000, 32'h0, 32'h0);
        #4;
        checks++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_idle: stall=%b whilo=%b wdata=%h, want 0/0/0", stallreq_o, whilo_o, wdata_o);
        end
    endtask

    task automatic test_alu();
        logic [106:0] tbl [0:13];
        logic [7:0]   op;
        logic [2:0]   sel;
        logic [31:0]  a, b, exp;
        tbl[0]  = {8'h25, 3'b001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF};
        tbl[1]  = {8'h23, 3'b100, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        tbl[2]  = {8'h2A, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        tbl[3]  = {8'h03, 3'b010, 32'h00000004, 32'h80000000, 32'hF8000000};
        tbl[4]  = {8'h02, 3'b010, 32'h00000004, 32'h80000000, 32'h08000000};
        tbl[5]  = {8'h7C, 3'b010, 32'h0000001F, 32'h00000001, 32'h80000000};
        tbl[6]  = {8'h24, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
        tbl[7]  = {8'h26, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F};
        tbl[8]  = {8'h27, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0};
        tbl[9]  = {8'h21, 3'b100, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        tbl[10] = {8'h2A, 3'b100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        tbl[11] = {8'h00, 3'b000, 32'h12345678, 32'h00000009, 32'h00000000};
        tbl[12] = {8'h25, 3'b111, 32'h0000F0F0, 32'h00000F0F, 32'h00000000};
        tbl[13] = {8'h03, 3'b010, 32'h00000024, 32'h80000000, 32'hF8000000};
        @(posedge clk); #1;
        wreg_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            {op, sel, a, b, exp} = tbl[i];
            waddr_i = 5'(i + 1);
            set_op(op, sel, a, b);
            #1;
            checks++;
            if (wdata_o !== exp) begin
                failures++;
                $display("FAIL alu_wdata[%0d] op=%h sel=%b a=%h b=%h: got %h, want %h", i, op, sel, a, b, wdata_o, exp);
            end
            checks++;
            if (wreg_o !== 1'b1 || waddr_o !== 5'(i + 1) || stallreq_o !== 1'b0) begin
                failures++;
                $display("FAIL alu_ctrl[%0d]: wreg=%b waddr=%0d stall=%b, want 1/%0d/0", i, wreg_o, waddr_o, stallreq_o, i + 1);
            end
        end
        wreg_i = 1'b0; waddr_i = 5'd0;
        set_op(8'h00, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_divide(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int len);
        int bad;
        bad = 0;
        @(posedge clk); #1;
        set_op(op, 3'b000, a, b);
        for (int c = 0; c < len; c++) begin
            #4;
            if (stallreq_o !== 1'b1 || whilo_o !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        #4;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL div_stall op=%h a=%h b=%h: %0d bad cycles in 0..%0d, want 0", op, a, b, bad, len - 1);
        end
        checks++;
        if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || lo_o !== exp_lo || hi_o !== exp_hi) begin
            failures++;
            $display("FAIL div_end op=%h a=%h b=%h: whilo=%b stall=%b lo=%h hi=%h, want 1/0 lo=%h hi=%h",
                     op, a, b, whilo_o, stallreq_o, lo_o, hi_o, exp_lo, exp_hi);
        end
        @(posedge clk); #1;
        set_op(8'h00, 3'b000, 32'h0, 32'h0);
        #4;
        checks++;
        if (whilo_o !== 1'b0 || stallreq_o !== 1'b0 || lo_o !== 32'h0 || hi_o !== 32'h0) begin
            failures++;
            $display("FAIL div_after op=%h: whilo=%b stall=%b lo=%h hi=%h, want all 0", op, whilo_o, stallreq_o, lo_o, hi_o);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        set_op(OP_DIVU, 3'b000, 32'd100, 32'd7);
        for (int c = 0; c < 68; c++) begin
            #4;
            if (c == 33 || c == 67) begin
                checks++;
                if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || lo_o !== 32'd14 || hi_o !== 32'd2) begin
                    failures++;
                    $display("FAIL b2b_end cycle %0d: whilo=%b stall=%b lo=%h hi=%h, want 1/0 lo=e hi=2",
                             c, whilo_o, stallreq_o, lo_o, hi_o);
                end
            end else if (stallreq_o !== 1'b1 || whilo_o !== 1'b0) begin
                bad++;
            end
            @(posedge clk); #1;
            if (c == 67) set_op(8'h00, 3'b000, 32'h0, 32'h0);
        end
        #4;
        checks++;
        if (bad !== 0 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall: %0d bad stall cycles, final stall=%b, want 0/0", bad, stallreq_o);
        end
    endtask

    task automatic test_flush();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        set_op(OP_DIVU, 3'b000, 32'd100, 32'd7);
        for (int c = 0; c < 10; c++) begin
            #4;
            if (stallreq_o !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        #4;
        checks++;
        if (bad !== 0 || stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_c10: bad=%0d stall=%b whilo=%b, want 0/0/0", bad, stallreq_o, whilo_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        set_op(8'h00, 3'b000, 32'h0, 32'h0);
        #4;
        checks++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_c11_free: stall=%b whilo=%b, want 0/0", stallreq_o, whilo_o);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL flush_no_end: %0d cycles with whilo/stall set, want 0", bad);
        end
    endtask

    task automatic test_rst_mid();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        wreg_i = 1'b1; waddr_i = 5'd5;
        set_op(OP_DIV, 3'b000, 32'd100, 32'd7);
        for (int c = 0; c < 10; c++) begin
            #4;
            if (stallreq_o !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #4;
        checks++;
        if (bad !== 0 || wreg_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'h0 ||
            whilo_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_c10: bad=%0d wreg=%b waddr=%0d wdata=%h whilo=%b hi=%h lo=%h stall=%b, want all 0",
                     bad, wreg_o, waddr_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; wreg_i = 1'b0; waddr_i = 5'd0;
        set_op(8'h00, 3'b000, 32'h0, 32'h0);
        #4;
        checks++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_c11_free: stall=%b whilo=%b, want 0/0", stallreq_o, whilo_o);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rst_no_end: %0d cycles with whilo/stall set, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_divide(OP_DIVU, 32'd100,       32'd7,       32'd14,       32'd2,       33);
        test_divide(OP_DIV,  32'hFFFFFFF9,  32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        test_divide(OP_DIV,  32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,       33);
        test_divide(OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'h0,       33);
        test_divide(OP_DIVU, 32'hFFFFFFFF,  32'd16,      32'h0FFFFFFF, 32'd15,      33);
        test_divide(OP_DIV,  32'd5,         32'd0,       32'h0,        32'h0,       2);
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_divide(OP_DIVU, 32'd100,       32'd7,       32'd14,       32'd2,       33);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
